// File: rtl/div_pkg.sv
// Shared types and constants for the E-stage iterative divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int          DIV_ITER   = 32;
   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

   // Two's-complement magnitude; raw value when the operation is unsigned.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] rq,
   input  logic [WIDTH-1:0]   divisor,
   output logic [2*WIDTH-1:0] rq_next
);

   // The shifted remainder needs one extra bit when the divisor exceeds 2^(WIDTH-1).
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             take;

   assign rem_sh  = rq[2*WIDTH-1:WIDTH-1];
   assign take    = (rem_sh >= {1'b0, divisor});
   assign diff    = rem_sh[WIDTH-1:0] - divisor;
   assign rq_next = take ? {diff, rq[WIDTH-2:0], 1'b1}
                         : {rem_sh[WIDTH-1:0], rq[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle sequencer for the 32-step restoring divider feeding the HI/LO write path.
// Optional build macro: DIV_EARLY_OUT_EN (skip CALC when |b| > |a|).
module div_sequencer
   import div_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ITER_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] div_a,
   input  logic [WIDTH-1:0] div_b,
   input  logic             flush,
   output logic             div_busy,
   output logic             div_complete,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   div_state_t         state;
   logic [ITER_W-1:0]  cnt;
   logic [2*WIDTH-1:0] rq;
   logic [2*WIDTH-1:0] rq_next;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   a_raw;
   logic               neg_q;
   logic               neg_r;

   logic [WIDTH-1:0]   a_mag_in;
   logic [WIDTH-1:0]   b_mag_in;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;
   logic               early_out;

   assign a_mag_in = mag32(div_a, div_signed);
   assign b_mag_in = mag32(div_b, div_signed);

`ifdef DIV_EARLY_OUT_EN
   assign early_out = (b_mag_in != '0) && (b_mag_in > a_mag_in);
`else
   assign early_out = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rq      (rq),
      .divisor (b_mag),
      .rq_next (rq_next)
   );

   // Divide by zero bypasses sign correction and returns the original dividend in HI.
   assign q_fix = (b_mag == '0) ? DIV_ZERO_Q : cond_neg(rq_next[WIDTH-1:0], neg_q);
   assign r_fix = (b_mag == '0) ? a_raw      : cond_neg(rq_next[2*WIDTH-1:WIDTH], neg_r);

   assign div_busy     = (state == CALC);
   assign div_complete = (state == DONE) && !flush;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         rq     <= '0;
         b_mag  <= '0;
         a_raw  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         res_lo <= '0;
         res_hi <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (div_start) begin
                  a_raw <= div_a;
                  b_mag <= b_mag_in;
                  neg_q <= div_signed & (div_a[WIDTH-1] ^ div_b[WIDTH-1]);
                  neg_r <= div_signed & div_a[WIDTH-1];
                  cnt   <= '0;
                  if (early_out) begin
                     res_lo <= '0;
                     res_hi <= div_a;
                     state  <= DONE;
                  end else begin
                     rq    <= {{WIDTH{1'b0}}, a_mag_in};
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rq  <= rq_next;
               cnt <= cnt + 1'b1;
               if (cnt == ITER_W'(DIV_ITER - 1)) begin
                  res_lo <= q_fix;
                  res_hi <= r_fix;
                  state  <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer; expected values are hand-computed.
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        flush;
   logic        div_busy;
   logic        div_complete;
   logic [31:0] res_lo;
   logic [31:0] res_hi;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef DIV_EARLY_OUT_EN
   localparam int EO_LAT = 1;
`else
   localparam int EO_LAT = 33;
`endif

   div_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .div_start    (div_start),
      .div_signed   (div_signed),
      .div_a        (div_a),
      .div_b        (div_b),
      .flush        (flush),
      .div_busy     (div_busy),
      .div_complete (div_complete),
      .res_lo       (res_lo),
      .res_hi       (res_hi)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a divide and wait for completion; operands are scrambled mid-CALC to prove latching.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int exp_lat);
      int n = 0;
      int busy_n = 0;
      div_a = a; div_b = b; div_signed = sgn; div_start = 1'b1;
      while (!div_complete && n < 100) begin
         tick();
         n++;
         if (div_busy) busy_n++;
         if (n == 3) begin
            div_a = 32'h1234_5678; div_b = 32'h0000_0003; div_signed = ~sgn;
         end
      end
      div_start = 1'b0;
      check({tag, "_lat"},  32'(n), 32'(exp_lat));
      check({tag, "_busy"}, 32'(busy_n), 32'(exp_lat - 1));
      check({tag, "_lo"},   res_lo, exp_lo);
      check({tag, "_hi"},   res_hi, exp_hi);
      tick();
      check({tag, "_pulse"}, {31'd0, div_complete}, 32'd0);
   endtask

   initial begin
      int n;
      reset = 1'b0; div_start = 1'b0; div_signed = 1'b0; flush = 1'b0;
      div_a = '0; div_b = '0;
      repeat (3) tick();
      check("rst_busy", {31'd0, div_busy}, 32'd0);
      check("rst_done", {31'd0, div_complete}, 32'd0);
      check("rst_lo", res_lo, 32'd0);
      check("rst_hi", res_hi, 32'd0);
      reset = 1'b1;
      tick();

      run_div("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33);
      run_div("s_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
      run_div("s_min_m1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          33);
      run_div("u5_0",     32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          33);
      run_div("s5_0",     32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          33);
      run_div("s_m5_0",   32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  33);

      // Flush at CALC cycle t+10, restart at t+12.
      div_a = 32'd1000; div_b = 32'd10; div_signed = 1'b0; div_start = 1'b1;
      repeat (10) tick();
      check("fl_calc_busy", {31'd0, div_busy}, 32'd1);
      flush = 1'b1; div_start = 1'b0;
      tick();
      flush = 1'b0;
      check("fl_idle_busy", {31'd0, div_busy}, 32'd0);
      check("fl_no_done", {31'd0, div_complete}, 32'd0);
      check("fl_keep_lo", res_lo, 32'hFFFF_FFFF);
      check("fl_keep_hi", res_hi, 32'hFFFF_FFFB);
      tick();
      run_div("after_fl", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);

      // Flush together with start in IDLE: no load.
      div_a = 32'd8; div_b = 32'd2; div_start = 1'b1; flush = 1'b1;
      tick();
      check("flst_busy", {31'd0, div_busy}, 32'd0);
      check("flst_done", {31'd0, div_complete}, 32'd0);
      flush = 1'b0; div_start = 1'b0;
      tick();
      check("flst_idle", {31'd0, div_busy}, 32'd0);

      // Back-to-back: start held across DONE with new operands.
      div_a = 32'd50; div_b = 32'd5; div_signed = 1'b0; div_start = 1'b1;
      n = 0;
      while (!div_complete && n < 100) begin tick(); n++; end
      check("b2b_first_lat", 32'(n), 32'd33);
      check("b2b_first_lo", res_lo, 32'd10);
      div_a = 32'd20; div_b = 32'd6;
      n = 0;
      do begin tick(); n++; end while (!div_complete && n < 100);
      check("b2b_gap", 32'(n), 32'd34);
      check("b2b_lo", res_lo, 32'd3);
      check("b2b_hi", res_hi, 32'd2);
      div_start = 1'b0;
      tick();

      run_div("u3_10", 32'd3,         32'd10, 1'b0, 32'd0, 32'd3,         EO_LAT);
      run_div("s_m3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, 32'd0, 32'hFFFF_FFFD, EO_LAT);

      // Reset mid-operation aborts to reset values.
      div_a = 32'd100; div_b = 32'd7; div_signed = 1'b0; div_start = 1'b1;
      repeat (5) tick();
      reset = 1'b0; div_start = 1'b0;
      tick();
      check("mrst_busy", {31'd0, div_busy}, 32'd0);
      check("mrst_lo", res_lo, 32'd0);
      check("mrst_hi", res_hi, 32'd0);
      reset = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for the E-stage iterative divider. It accepts a divide request from the execute stage, sequences a 32-step restoring division over latched operands, applies sign correction, and presents the quotient and remainder for the HI/LO write path. It produces the `div_complete` pulse consumed by the mul/div hazard logic, where `div_stall = div_start & ~div_complete`. A pipeline flush cancels any divide in flight.

## Interface
- `WIDTH`, 32, operand width; only 32 is supported.
- `ITER_W`, 6, iteration counter width; must satisfy 2^ITER_W > WIDTH.

- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low; sampled on the `clk` rising edge.
- `div_start` input 1: divide request from E. Held high until `div_complete` is seen.
- `div_signed` input 1: 1 selects DIV, 0 selects DIVU. Sampled with `div_start` in IDLE.
- `div_a` input 32: dividend. Sampled in IDLE.
- `div_b` input 32: divisor. Sampled in IDLE.
- `flush` input 1: cancels the current operation; has priority over everything except reset.
- `div_busy` output 1: high in CALC.
- `div_complete` output 1: one-cycle pulse in DONE.
- `res_lo` output 32: quotient, the LO value.
- `res_hi` output 32: remainder, the HI value.

## Operation
- States: IDLE, CALC, DONE.
- IDLE + `div_start` + !`flush`:
  - latch |a| and |b| (magnitudes when `div_signed`, raw values otherwise);
  - latch the quotient-negate flag (`a[31]^b[31]`) and the remainder-negate flag (`a[31]`), both gated by `div_signed`;
  - clear the 64-bit partial remainder and the counter; go to CALC.
- CALC:
  - each cycle, shift {rem, quo} left by 1;
  - compare rem[63:32] against |b|; on ≥, subtract and set quo bit 0;
  - increment the counter; after the step with counter == 31, go to DONE.
- DONE:
  - `div_complete`=1 for exactly one cycle;
  - `res_lo` and `res_hi` are registered already sign-corrected;
  - return to IDLE.
- Results hold until the next load; they are not cleared on IDLE.
- Input changes during CALC or DONE are ignored; operands are latched.
- `div_start` still high in the IDLE cycle after DONE is treated as a new instruction (back-to-back divides), because the pipeline advanced on `div_complete`.
- Divide by zero: `res_lo`=32'hFFFFFFFF and `res_hi`=`div_a`, regardless of `div_signed`. The sign fix is suppressed.
- Signed 0x80000000 / -1: `res_lo`=0x80000000, `res_hi`=0. The result wraps with no trap.
- `flush` in any state: go to IDLE at the next edge, no `div_complete`, and results are left unchanged. When `flush` and `div_start` are both high in IDLE, no load occurs.
- Reset mid-operation: immediate abort to reset values.

## Timing
- Reset values: state=IDLE, `div_busy`=0, `div_complete`=0, `res_lo`=0, `res_hi`=0, counter=0.
- Start first seen in IDLE at cycle t:
  - CALC occupies t+1..t+32;
  - `div_complete` and valid results occur at t+33;
  - `div_busy` is high t+1..t+32.
- Minimum spacing between two completions is 34 cycles (one IDLE cycle between divides).
- `div_complete` never asserts in a cycle with `flush`=1.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - in IDLE, if |b| > |a| (unsigned magnitudes, b≠0), skip CALC and go straight to DONE;
  - result is `res_lo`=0 and `res_hi`=`div_a` (sign preserved);
  - `div_complete` occurs at t+1.
- `DIV_EARLY_OUT_EN` undefined: every divide takes the full 33 cycles, and the magnitude comparator is not built.

## Structure
- Shared package `div_pkg`:
  - state enum `div_state_t` {IDLE, CALC, DONE};
  - `DIV_ITER`=32;
  - `DIV_ZERO_Q`=32'hFFFFFFFF.
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: 64-bit {rem, quo}, 32-bit divisor.
  - Outputs: next {rem, quo}.
  - Instantiated once inside the CALC datapath.

## Test plan
- Unsigned 100 / 7, start at t → `div_complete` at t+33 with `res_lo`=14, `res_hi`=2; `div_busy` high t+1..t+32.
- Signed -7 / 2 → `res_lo`=0xFFFFFFFD, `res_hi`=0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF → `res_lo`=0x80000000, `res_hi`=0.
- Divide by zero, 5 / 0, both signed and unsigned → `res_lo`=0xFFFFFFFF, `res_hi`=5, `div_complete` at t+33.
- `flush` at the CALC cycle t+10 → state IDLE at t+11, no `div_complete`, old results retained. A new start at t+12 (9 / 3) → complete at t+45 with `res_lo`=3, `res_hi`=0.
- Back-to-back: `div_start` held across the DONE cycle with new operands 20 / 6 → second complete 34 cycles after the first, `res_lo`=3, `res_hi`=2.
- Unsigned 3 / 10 → with `DIV_EARLY_OUT_EN` defined, `div_complete` at t+1 with `res_lo`=0, `res_hi`=3; without it, the same values at t+33.
